// File: rtl/alu_operand_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : alu_operand_sequencer_pkg                                     |
// | Purpose  : Shared ALU test definitions: sequencer state encoding,        |
// |            signature polynomial taps and the signature update function.  |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
package alu_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Feedback taps of the 16-bit signature register: bits 15, 13, 12, 10.
  localparam logic [15:0] c_sig_taps = 16'hB400;

  // Shift left with tap feedback into bit 0, then fold in the captured data.
  function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [15:0] din);
    return {sig[14:0], ^(sig & c_sig_taps)} ^ din;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_sequencer_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : alu_operand_sequencer_reg                                     |
// | Purpose  : W-bit register with synchronous active-high clear.            |
// | Ports    : clk, reset (sync, active-high), d [W-1:0] in, q [W-1:0] out.  |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module alu_operand_sequencer_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : alu_operand_sequencer                                         |
// | Purpose  : Sweeps every (opcode, a, b) vector into a registered ALU      |
// |            stage, captures result/flags LAT cycles later and folds them  |
// |            into a running 16-bit signature.                              |
// | Ports    : clk, reset (sync, active-high), start (pulse), pause (level), |
// |            a/b [n-1:0] and opcode [3:0] to the ALU stage,                |
// |            result_in [n-1:0], N_in/Z_in/C_in/V_in from the ALU stage,    |
// |            busy, done, vec_count [2n+4:0], signature [15:0].             |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int         n       = 2,
  parameter logic [3:0] OP_LAST = 4'd9,
  parameter int         LAT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  output logic [n-1:0]     a,
  output logic [n-1:0]     b,
  output logic [3:0]       opcode,
  input  logic [n-1:0]     result_in,
  input  logic             N_in,
  input  logic             Z_in,
  input  logic             C_in,
  input  logic             V_in,
  output logic             busy,
  output logic             done,
  output logic [2*n+4:0]   vec_count,
  output logic [15:0]      signature
);

  localparam int             c_vw        = 2 * n + 5;
  localparam logic [c_vw-1:0] c_vec_one  = c_vw'(1);
  localparam logic [n-1:0]   c_opnd_one  = n'(1);
  // Oldest stage of the marker pipe; its marker is consumed this cycle.
  localparam logic [LAT-1:0] c_pipe_tail = LAT'(1) << (LAT - 1);

  seq_state_t       state_q, state_d;
  logic [n-1:0]     a_q, a_d;
  logic [n-1:0]     b_q, b_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [c_vw-1:0]  vec_count_q, vec_count_d;
  logic [15:0]      signature_q, signature_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LAT-1:0]   pipe_d;
  logic [LAT-1:0]   pipe_q;

  logic             w_issue;
  logic             w_capture;
  logic             w_last_vec;
  logic             w_in_flight;

  assign w_issue    = (state_q == ST_RUN) && !pause;
  assign w_capture  = pipe_q[LAT-1];
  assign w_last_vec = (a_q == '1) && (b_q == '1) && (opcode_q == OP_LAST);
  // Markers other than the one being captured right now.
  assign w_in_flight = |(pipe_q & ~c_pipe_tail);

  // Issue-marker pipe: stage 0 takes this cycle's issue flag, each later
  // stage takes its predecessor. A bubble is simply a 0 marker.
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = w_issue;
      end else begin : g_body
        assign pipe_d[gi] = pipe_q[gi-1];
      end
      alu_operand_sequencer_reg #(
        .W (1)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .d     (pipe_d[gi]),
        .q     (pipe_q[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    opcode_d    = opcode_q;
    vec_count_d = vec_count_q;
    signature_d = signature_q;

    if (w_capture) begin
      vec_count_d = vec_count_q + c_vec_one;
      signature_d = sig_step(signature_q, 16'({N_in, Z_in, C_in, V_in, result_in}));
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          a_d         = '0;
          b_d         = '0;
          opcode_d    = '0;
          vec_count_d = '0;
          signature_d = '0;
        end
      end
      ST_RUN: begin
        if (w_issue) begin
          // The last vector stays on a/b/opcode through DRAIN and DONE.
          if (w_last_vec) begin
            state_d = ST_DRAIN;
          end else if (b_q == '1) begin
            b_d = '0;
            if (a_q == '1) begin
              a_d      = '0;
              opcode_d = opcode_q + 4'd1;
            end else begin
              a_d = a_q + c_opnd_one;
            end
          end else begin
            b_d = b_q + c_opnd_one;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_in_flight) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      opcode_q    <= '0;
      vec_count_q <= '0;
      signature_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opcode_q    <= opcode_d;
      vec_count_q <= vec_count_d;
      signature_q <= signature_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign opcode    = opcode_q;
  assign vec_count = vec_count_q;
  assign signature = signature_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_alu_operand_sequencer                                      |
// | Purpose  : Self-checking bench for alu_operand_sequencer with an         |
// |            attached two-stage registered ALU.                            |
// | Revision : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;

  localparam int         N_W   = 2;
  localparam logic [3:0] OPL   = 4'd1;
  localparam int         LT    = 2;
  localparam int         TOTAL = (int'(OPL) + 1) << (2 * N_W);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             pause;
  logic [N_W-1:0]   a, b;
  logic [3:0]       opcode;
  logic [N_W-1:0]   result_in;
  logic             N_in, Z_in, C_in, V_in;
  logic             busy, done;
  logic [2*N_W+4:0] vec_count;
  logic [15:0]      signature;

  int checks = 0;
  int errors = 0;

  logic [15:0] sig_after [0:TOTAL];

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .n       (N_W),
    .OP_LAST (OPL),
    .LAT     (LT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .result_in (result_in),
    .N_in      (N_in),
    .Z_in      (Z_in),
    .C_in      (C_in),
    .V_in      (V_in),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count),
    .signature (signature)
  );

  // Small ALU: even opcodes add, odd opcodes subtract; {N,Z,C,V,result}.
  function automatic logic [5:0] alu_f(input int av, input int bv, input int opv);
    int s, r;
    logic c, v, sa, sb, sr;
    if (opv % 2 == 0) begin
      s = av + bv;
      c = (s > 3);
    end else begin
      s = av - bv;
      c = (s < 0);
    end
    r  = (s + 4) % 4;
    sa = (av >= 2);
    sb = (bv >= 2);
    sr = (r >= 2);
    v  = (opv % 2 == 0) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
    return {sr, (r == 0), c, v, r[1:0]};
  endfunction

  // Registered ALU stage, LT = 2 cycles from operands to result.
  logic [5:0] s1, s2;
  always @(posedge clk) begin
    s1 <= alu_f(int'(a), int'(b), int'(opcode));
    s2 <= s1;
  end
  assign {N_in, Z_in, C_in, V_in, result_in} = s2;

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [5:0] d);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {10'd0, d};
  endfunction

  function automatic int vec_b(input int k); return k % 4; endfunction
  function automatic int vec_a(input int k); return (k / 4) % 4; endfunction
  function automatic int vec_o(input int k); return k / 16; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int k);
    chk({tag, "_a"}, 32'(a), 32'(vec_a(k)));
    chk({tag, "_b"}, 32'(b), 32'(vec_b(k)));
    chk({tag, "_op"}, 32'(opcode), 32'(vec_o(k)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cnt"}, 32'(vec_count), 32'd0);
    chk({tag, "_sig"}, 32'(signature), 32'd0);
    chk_vec(tag, 0);
  endtask

  // One full sweep from IDLE or DONE. Pause is either random or a directed
  // window of cycles [p_at, p_at+p_len); start is re-pulsed in cycle st_at.
  task automatic sweep(input bit rnd_pause, input int p_at, input int p_len, input int st_at);
    int k, cyc, paused, exp_cnt;
    bit p;
    int issue_cyc[$];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_cnt", 32'(vec_count), 32'd0);
    chk("start_sig", 32'(signature), 32'd0);
    k = 0;
    cyc = 1;
    paused = 0;
    while (done !== 1'b1 && cyc <= 2000) begin
      if (k < TOTAL) chk_vec("run_vec", k);
      else           chk_vec("drain_hold", TOTAL - 1);
      exp_cnt = 0;
      foreach (issue_cyc[i]) if (issue_cyc[i] + LT + 1 <= cyc) exp_cnt++;
      chk("run_cnt", 32'(vec_count), 32'(exp_cnt));
      chk("run_sig", 32'(signature), 32'(sig_after[exp_cnt]));
      chk("run_busy", 32'(busy), 32'd1);
      if (rnd_pause) p = ($urandom_range(0, 3) == 0);
      else           p = (cyc >= p_at) && (cyc < p_at + p_len);
      pause = p;
      start = (cyc == st_at);
      if (k < TOTAL) begin
        if (p) paused++;
        else begin
          issue_cyc.push_back(cyc);
          k++;
        end
      end
      step();
      cyc++;
    end
    pause = 1'b0;
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_cycles", 32'(cyc - 1), 32'(TOTAL + LT + paused));
    chk("done_busy", 32'(busy), 32'd0);
    chk("final_cnt", 32'(vec_count), 32'(TOTAL));
    chk("final_sig", 32'(signature), 32'(sig_after[TOTAL]));
    chk_vec("done_vec", TOTAL - 1);
    pause = 1'b1;
    step();
    step();
    pause = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_hold_cnt", 32'(vec_count), 32'(TOTAL));
    chk("done_hold_sig", 32'(signature), 32'(sig_after[TOTAL]));
  endtask

  initial begin
    sig_after[0] = 16'd0;
    for (int m = 0; m < TOTAL; m++)
      sig_after[m+1] = ref_step(sig_after[m], alu_f(vec_a(m), vec_b(m), vec_o(m)));

    // Reset overrides a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    pause = 1'b0;
    step();
    step();
    start = 1'b0;
    chk_idle("reset");
    reset = 1'b0;
    step();
    chk_idle("idle");

    // Plain sweep from IDLE.
    sweep(1'b0, 0, 0, -1);
    // Restart from DONE with a 5-cycle pause mid-RUN.
    sweep(1'b0, 20, 5, -1);
    // Pause covering the cycle the last vector would issue.
    sweep(1'b0, 32, 3, -1);
    // Random pause pattern and a stray start pulse while busy.
    sweep(1'b1, 0, 0, int'($urandom_range(2, 30)));

    // Reset while vector 10 is on the operands.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk_vec("pre_reset_vec", 10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("mid_reset");
    repeat (3) step();
    chk_idle("post_reset");
    // Full sweep after the abort, with a start pulse ignored in RUN.
    sweep(1'b0, 0, 0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
